// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding byte/half/word access on a req/gnt/rvalid bus,
// with alignment fault detection, bus timeout and sign/zero extension of loads.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic        MemWr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, RDATA, RESP} state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        w_accept;
  logic        w_fault;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'd0:    return 4'b0001 << lane;
      2'd1:    return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {lane, 3'b000});
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  assign w_accept = req_valid && (MemRead ^ MemWr);
  assign busy     = (r_state == ADDR) || (r_state == RDATA);

  always_comb begin
    w_fault = 1'b0;
    if (funct3 == 3'd3 || funct3[2:1] == 2'b11) w_fault = 1'b1;
    if (MemWr && funct3[2])                     w_fault = 1'b1;
    if (funct3[1:0] == 2'd1 && addr[0])         w_fault = 1'b1;
    if (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0) w_fault = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_lane     <= 2'd0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      load_data  <= 32'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 30'd0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_store <= MemWr;
            r_funct3   <= funct3;
            r_lane     <= addr[1:0];
            if (w_fault) begin
              r_state    <= RESP;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              r_state   <= ADDR;
              r_cnt     <= 8'd0;
              mem_req   <= 1'b1;
              mem_we    <= MemWr;
              mem_addr  <= addr[31:2];
              mem_wstrb <= MemWr ? store_strb(funct3, addr[1:0]) : 4'd0;
              mem_wdata <= MemWr ? store_data(funct3, write_data) : 32'd0;
            end
          end
        end
        ADDR: begin
          // A grant on the last counted cycle still completes normally.
          if (mem_gnt || r_cnt == LP_CNT_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            if (!mem_gnt) begin
              r_state <= RESP;
              done    <= 1'b1;
              bus_err <= 1'b1;
            end else if (r_is_store) begin
              r_state <= RESP;
              done    <= 1'b1;
            end else begin
              r_state <= RDATA;
              r_cnt   <= 8'd0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RDATA: begin
          if (mem_rvalid) begin
            load_data <= load_extend(r_funct3, r_lane, mem_rdata);
            r_state   <= RESP;
            done      <= 1'b1;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= RESP;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          done       <= 1'b0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and randomized transactions checked against
// a byte-lane reference model of the load/store rules.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk;
  logic        n_rst;
  logic        req_valid;
  logic        MemRead;
  logic        MemWr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_ld;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .MemRead(MemRead), .MemWr(MemWr),
    .funct3(funct3), .addr(addr), .write_data(write_data), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accesses described as n consecutive bytes starting at a byte offset.
  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [1:0] a);
    int n;
    n = m_size(f3);
    if (n == 0) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    return (int'(a) % n) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = m_size(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(int'(a)+i) +: 8];
    if (f3 < 3'd4 && n < 4 && v[8*n-1])
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < m_size(f3); i++) s[int'(a)+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int n;
    n = m_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i%n) +: 8];
    return w;
  endfunction

  // Issue one request and follow it cycle by cycle. g = cycles before grant,
  // r = cycles in RDATA before rvalid; junk drives ignorable noise meanwhile.
  task automatic run_txn(input string nm, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int g, input int r, input bit junk);
    bit leg, berr, in_a, in_r, ok_load;
    int ga, ra, resp_k;
    logic [31:0] old_ld, new_ld, rnd;
    leg    = m_legal(st, f3, a[1:0]);
    ga     = (g < TO) ? g : TO - 1;
    ra     = (r < TO) ? r : TO - 1;
    berr   = leg && (g >= TO || (!st && r >= TO));
    resp_k = !leg ? 0 : (st || g >= TO) ? ga + 1 : ga + 2 + ra;
    ok_load = leg && !st && !berr;
    old_ld = exp_ld;
    new_ld = ok_load ? m_load(f3, a[1:0], rd) : exp_ld;
    req_valid = 1'b1; MemRead = !st; MemWr = st; funct3 = f3; addr = a; write_data = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k <= resp_k + 1; k++) begin
      in_a = leg && k <= ga;
      in_r = leg && !st && g < TO && k > ga && k < resp_k;
      n_checks++;
      if (busy !== (in_a || in_r)) $display("FAIL %s busy k=%0d got %b want %b", nm, k, busy, in_a || in_r);
      else n_pass++;
      n_checks++;
      if (mem_req !== in_a) $display("FAIL %s mem_req k=%0d got %b want %b", nm, k, mem_req, in_a);
      else n_pass++;
      n_checks++;
      if (done !== (k == resp_k)) $display("FAIL %s done k=%0d got %b want %b", nm, k, done, k == resp_k);
      else n_pass++;
      n_checks++;
      if (misaligned !== (k == resp_k && !leg))
        $display("FAIL %s misaligned k=%0d got %b want %b", nm, k, misaligned, k == resp_k && !leg);
      else n_pass++;
      n_checks++;
      if (bus_err !== (k == resp_k && berr))
        $display("FAIL %s bus_err k=%0d got %b want %b", nm, k, bus_err, k == resp_k && berr);
      else n_pass++;
      exp_ld = (k >= resp_k) ? new_ld : old_ld;
      n_checks++;
      if (load_data !== exp_ld) $display("FAIL %s load_data k=%0d got %h want %h", nm, k, load_data, exp_ld);
      else n_pass++;
      if (in_a) begin
        n_checks++;
        if (mem_we !== st || mem_addr !== a[31:2] || mem_wstrb !== (st ? m_strb(f3, a[1:0]) : 4'd0) ||
            mem_wdata !== (st ? m_wdata(f3, wd) : 32'd0))
          $display("FAIL %s mem_bus k=%0d got we=%b a=%h s=%b d=%h want we=%b a=%h s=%b d=%h", nm, k,
                   mem_we, mem_addr, mem_wstrb, mem_wdata, st, a[31:2],
                   st ? m_strb(f3, a[1:0]) : 4'd0, st ? m_wdata(f3, wd) : 32'd0);
        else n_pass++;
      end
      if (k <= resp_k) begin
        mem_gnt = leg && (k == g);
        mem_rvalid = (!st && leg && k == g + 1 + r) || (junk && in_a && $urandom_range(0, 1) == 1);
        if (junk) begin
          rnd = $urandom();
          req_valid = rnd[0]; MemRead = rnd[1]; MemWr = rnd[2]; funct3 = rnd[5:3];
          addr = $urandom(); write_data = $urandom();
        end
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0; MemRead = 1'b0; MemWr = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req_valid = 1'b1; MemRead = 1'b1; MemWr = 1'b0; funct3 = 3'd2;
    addr = 32'h100; write_data = 32'h1234; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, misaligned, bus_err, mem_req, mem_we} !== 6'd0 || mem_wstrb !== 4'd0 ||
        mem_addr !== 30'd0 || mem_wdata !== 32'd0 || load_data !== 32'd0)
      $display("FAIL reset_outputs got b=%b d=%b m=%b e=%b r=%b we=%b s=%b a=%h wd=%h ld=%h want all 0",
               busy, done, misaligned, bus_err, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, load_data);
    else n_pass++;
    n_rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_ld = 32'd0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_release got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_txn("sb_0x103", 1'b1, 3'd0, 32'h103, 32'hA5, 32'h0, 0, 0, 1'b0);
    run_txn("lb_0x102", 1'b0, 3'd0, 32'h102, 32'h0, 32'h0080_0000, 0, 0, 1'b0);
    run_txn("lbu_0x102", 1'b0, 3'd4, 32'h102, 32'h0, 32'h0080_0000, 0, 0, 1'b0);
    run_txn("lw_0x002", 1'b0, 3'd2, 32'h002, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_txn("lh_0x4", 1'b0, 3'd1, 32'h4, 32'h0, 32'h8001_0000, 3, 1, 1'b0);
    run_txn("lh_0x6", 1'b0, 3'd1, 32'h6, 32'h0, 32'h8001_0000, 3, 1, 1'b0);
    run_txn("sh_0x102", 1'b1, 3'd1, 32'h102, 32'h1234_BEEF, 32'h0, 1, 0, 1'b0);
    run_txn("sw_0x200", 1'b1, 3'd2, 32'h200, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0);
    run_txn("sh_f3_4", 1'b1, 3'd4, 32'h200, 32'h1, 32'h0, 0, 0, 1'b0);
    run_txn("lhu_odd", 1'b0, 3'd5, 32'h201, 32'h0, 32'h1, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("ld_gnt_never", 1'b0, 3'd2, 32'h40, 32'h0, 32'h1111_2222, TO, 0, 1'b0);
    run_txn("ld_gnt_last", 1'b0, 3'd2, 32'h40, 32'h0, 32'h3333_4444, TO - 1, 0, 1'b0);
    run_txn("st_gnt_never", 1'b1, 3'd2, 32'h44, 32'h5, 32'h0, TO + 4, 0, 1'b0);
    run_txn("ld_rv_never", 1'b0, 3'd2, 32'h48, 32'h0, 32'h5555_6666, 1, TO, 1'b0);
    run_txn("ld_rv_last", 1'b0, 3'd1, 32'h4A, 32'h0, 32'h7FFF_0000, 0, TO - 1, 1'b0);
  endtask

  task automatic test_no_accept();
    req_valid = 1'b1; MemRead = 1'b1; MemWr = 1'b1; funct3 = 3'd2; addr = 32'h80;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0)
      $display("FAIL both_ops got busy=%b req=%b done=%b want 0 0 0", busy, mem_req, done);
    else n_pass++;
    MemRead = 1'b0; MemWr = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0)
      $display("FAIL no_op got busy=%b req=%b done=%b want 0 0 0", busy, mem_req, done);
    else n_pass++;
    req_valid = 1'b0; MemRead = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || load_data !== exp_ld)
      $display("FAIL no_valid got busy=%b req=%b ld=%h want 0 0 %h", busy, mem_req, load_data, exp_ld);
    else n_pass++;
    MemRead = 1'b0;
  endtask

  task automatic test_random();
    bit st;
    logic [2:0] f3;
    logic [31:0] a, wd, rd;
    int g, r;
    for (int i = 0; i < 60; i++) begin
      st = ($urandom_range(0, 1) == 1);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      a  = $urandom();
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
      wd = $urandom();
      rd = $urandom();
      g  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 3);
      r  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 3);
      run_txn($sformatf("rand%0d", i), st, f3, a, wd, rd, g, r, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_sw", 1'b1, 3'd2, 32'h300, 32'h0102_0304, 32'h0, 0, 0, 1'b0);
    run_txn("b2b_lb", 1'b0, 3'd0, 32'h301, 32'h0, 32'h0000_FF00, 0, 0, 1'b0);
    run_txn("b2b_bad", 1'b0, 3'd7, 32'h300, 32'h0, 32'h0, 0, 0, 1'b0);
    run_txn("b2b_lhu", 1'b0, 3'd5, 32'h302, 32'h0, 32'hF00D_0000, 0, 0, 1'b0);
  endtask

  task automatic test_reset_midtxn();
    req_valid = 1'b1; MemRead = 1'b1; MemWr = 1'b0; funct3 = 3'd2; addr = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || mem_req !== 1'b0) $display("FAIL mid_rdata got busy=%b req=%b want 1 0", busy, mem_req);
    else n_pass++;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    exp_ld = 32'd0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || load_data !== 32'd0 || bus_err !== 1'b0)
      $display("FAIL mid_reset got busy=%b done=%b req=%b ld=%h err=%b want 0 0 0 0 0",
               busy, done, mem_req, load_data, bus_err);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || load_data !== 32'd0)
        $display("FAIL late_rvalid k=%0d got busy=%b done=%b ld=%h want 0 0 0", k, busy, done, load_data);
      else n_pass++;
    end
    mem_rvalid = 1'b0;
    run_txn("after_reset_lw", 1'b0, 3'd2, 32'h504, 32'h0, 32'h2468_ACE0, 0, 0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; exp_ld = 32'd0;
    n_rst = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWr = 1'b0; funct3 = 3'd0;
    addr = 32'd0; write_data = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_directed();
    test_timeout();
    test_no_accept();
    test_back_to_back();
    test_random();
    test_reset_midtxn();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
